// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor: a table of 2-bit saturating counters
// indexed by PC[IdxBits+1:2]. Fetch gets a registered taken/not-taken guess
// one cycle after asking; execute trains the table with resolved outcomes
// and the block counts mispredictions.
//
// state | meaning
// INIT  | sweeping the table to weakly not-taken, requests ignored
// RUN   | predicting and training, left only by reset
module branch_predictor #(
    parameter int Entries  = 64,
    parameter int IdxBits  = $clog2(Entries),
    parameter int RegWidth = 32
) (
    input  logic                iClk,
    input  logic                nRst,
    input  logic                iPredValid,
    input  logic [RegWidth-1:0] iPredPC,
    output logic                oPredValid,
    output logic                oPredTaken,
    input  logic                iUpdValid,
    input  logic [RegWidth-1:0] iUpdPC,
    input  logic                iUpdTaken,
    input  logic                iUpdPredTaken,
    output logic                oMispredict,
    output logic [15:0]         oMissCount,
    output logic                oReady
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               run_en;
    logic               sweep_done;
    logic [IdxBits-1:0] sweep_ptr;
    logic [IdxBits-1:0] pred_idx;
    logic [IdxBits-1:0] upd_idx;
    logic [1:0]         upd_cnt;
    logic [1:0]         upd_cnt_next;
    logic [1:0]         cnt_table [Entries];
    logic               unused_pc_bits;

    assign pred_idx   = iPredPC[IdxBits+1:2];
    assign upd_idx    = iUpdPC[IdxBits+1:2];
    assign sweep_done = (sweep_ptr == IdxBits'(Entries - 1));
    assign upd_cnt    = cnt_table[upd_idx];

    // Byte offset and high PC bits do not take part in indexing.
    assign unused_pc_bits = ^{iPredPC[RegWidth-1:IdxBits+2], iPredPC[1:0],
                              iUpdPC[RegWidth-1:IdxBits+2], iUpdPC[1:0]};

    // State register
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) state <= INIT;
        else       state <= state_next;
    end

    // Next-state logic: leave INIT after the last entry is written
    always_comb begin
        state_next = state;
        if (state == INIT && sweep_done) state_next = RUN;
    end

    // Output decode of the FSM
    always_comb begin
        run_en = (state == RUN);
        oReady = (state == RUN);
    end

    // Sweep pointer walks the table once per INIT pass
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst)              sweep_ptr <= '0;
        else if (state == INIT) sweep_ptr <= sweep_ptr + IdxBits'(1);
    end

    // Saturating step of the counter being trained
    always_comb begin
        upd_cnt_next = upd_cnt;
        if (iUpdTaken) begin
            if (upd_cnt != 2'b11) upd_cnt_next = upd_cnt + 2'd1;
        end else begin
            if (upd_cnt != 2'b00) upd_cnt_next = upd_cnt - 2'd1;
        end
    end

    // Counter table: no reset, the INIT sweep gives it a defined value
    always_ff @(posedge iClk) begin
        if (!run_en)        cnt_table[sweep_ptr] <= 2'b01;
        else if (iUpdValid) cnt_table[upd_idx]   <= upd_cnt_next;
    end

    // Registered prediction; the read sees the table before this edge's update
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oPredValid <= 1'b0;
            oPredTaken <= 1'b0;
        end else if (run_en && iPredValid) begin
            oPredValid <= 1'b1;
            oPredTaken <= cnt_table[pred_idx][1];
        end else begin
            oPredValid <= 1'b0;
        end
    end

    // Misprediction pulse and saturating miss counter
    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            oMispredict <= 1'b0;
            oMissCount  <= 16'h0000;
        end else if (run_en && iUpdValid && (iUpdTaken != iUpdPredTaken)) begin
            oMispredict <= 1'b1;
            if (oMissCount != 16'hFFFF) oMissCount <= oMissCount + 16'd1;
        end else begin
            oMispredict <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus random
// traffic, every cycle compared against a behavioural table model.
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        iClk = 1'b0;
    logic        nRst = 1'b1;
    logic        iPredValid = 1'b0;
    logic [31:0] iPredPC = '0;
    logic        oPredValid;
    logic        oPredTaken;
    logic        iUpdValid = 1'b0;
    logic [31:0] iUpdPC = '0;
    logic        iUpdTaken = 1'b0;
    logic        iUpdPredTaken = 1'b0;
    logic        oMispredict;
    logic [15:0] oMissCount;
    logic        oReady;

    branch_predictor #(.Entries(ENTRIES)) dut (
        .iClk          (iClk),
        .nRst          (nRst),
        .iPredValid    (iPredValid),
        .iPredPC       (iPredPC),
        .oPredValid    (oPredValid),
        .oPredTaken    (oPredTaken),
        .iUpdValid     (iUpdValid),
        .iUpdPC        (iUpdPC),
        .iUpdTaken     (iUpdTaken),
        .iUpdPredTaken (iUpdPredTaken),
        .oMispredict   (oMispredict),
        .oMissCount    (oMissCount),
        .oReady        (oReady)
    );

    always #5 iClk = ~iClk;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural model: counters as plain integers 0..3
    int cnt_m [ENTRIES];
    int miss_m;
    int init_cycles;
    bit ready_m;
    bit exp_pv, exp_pt, exp_mp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) cnt_m[i] = 1;
        miss_m = 0; init_cycles = 0; ready_m = 0;
        exp_pv = 0; exp_pt = 0; exp_mp = 0;
    endtask

    task automatic idle();
        iPredValid = 0; iUpdValid = 0;
        iPredPC = '0; iUpdPC = '0; iUpdTaken = 0; iUpdPredTaken = 0;
    endtask

    // One clock: update model from current inputs, advance, compare outputs
    task automatic cycle();
        int u;
        if (ready_m) begin
            exp_pv = iPredValid;
            if (iPredValid) exp_pt = (cnt_m[idx_of(iPredPC)] >= 2);
            exp_mp = iUpdValid && (iUpdTaken != iUpdPredTaken);
            if (iUpdValid) begin
                u = idx_of(iUpdPC);
                if (iUpdTaken) cnt_m[u] = (cnt_m[u] == 3) ? 3 : cnt_m[u] + 1;
                else           cnt_m[u] = (cnt_m[u] == 0) ? 0 : cnt_m[u] - 1;
            end
            if (exp_mp && miss_m < 65535) miss_m++;
        end else begin
            exp_pv = 0; exp_mp = 0;
            init_cycles++;
            if (init_cycles == ENTRIES) ready_m = 1;
        end
        @(posedge iClk); #1;
        chk("pred_valid", oPredValid, exp_pv);
        chk("pred_taken", oPredTaken, exp_pt);
        chk("mispredict", oMispredict, exp_mp);
        chk("miss_count", oMissCount, miss_m);
        chk("ready", oReady, ready_m);
    endtask

    // Async reset pulse: outputs must clear before any clock edge
    task automatic do_reset();
        nRst = 0;
        model_reset();
        #1;
        chk("rst_pred_valid", oPredValid, 0);
        chk("rst_pred_taken", oPredTaken, 0);
        chk("rst_mispredict", oMispredict, 0);
        chk("rst_miss_count", oMissCount, 0);
        chk("rst_ready", oReady, 0);
        @(posedge iClk); #1;
        nRst = 1;
    endtask

    task automatic predict(input logic [31:0] pc);
        idle(); iPredValid = 1; iPredPC = pc; cycle();
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic used);
        idle(); iUpdValid = 1; iUpdPC = pc; iUpdTaken = taken; iUpdPredTaken = used;
        cycle();
    endtask

    int pulses;
    int miss_before;

    initial begin
        idle();
        #2;
        do_reset();

        // INIT sweep with no traffic
        for (int i = 0; i < ENTRIES; i++) begin
            idle(); cycle();
            if (i == ENTRIES - 2) chk("ready_low_c63", oReady, 0);
        end
        chk("ready_high_c64", oReady, 1);

        predict(32'h0000_0100);
        chk("fresh_0x100", oPredTaken, 0);
        predict(32'h0000_01FC);
        chk("fresh_0x1FC", oPredTaken, 0);

        // Train taken once at 0x100, then alias via 0x200
        update(32'h100, 1, 1);
        predict(32'h100);
        chk("trained_0x100", oPredTaken, 1);
        predict(32'h200);
        chk("alias_0x200", oPredTaken, 1);

        // Saturation at 0x104
        for (int i = 0; i < 4; i++) update(32'h104, 1, 1);
        update(32'h104, 0, 0);
        predict(32'h104);
        chk("sat_high_then_dec", oPredTaken, 1);
        for (int i = 0; i < 3; i++) update(32'h104, 0, 0);
        predict(32'h104);
        chk("sat_low", oPredTaken, 0);

        // Same-cycle predict and update at 0x108: read-before-write
        idle();
        iPredValid = 1; iPredPC = 32'h108;
        iUpdValid = 1; iUpdPC = 32'h108; iUpdTaken = 1; iUpdPredTaken = 1;
        cycle();
        chk("rbw_same_cycle", oPredTaken, 0);
        predict(32'h108);
        chk("rbw_next_cycle", oPredTaken, 1);

        // Five mispredicts interleaved with three matches
        pulses = 0;
        miss_before = oMissCount;
        for (int i = 0; i < 8; i++) begin
            logic t;
            t = 1'($urandom);
            if (i == 1 || i == 4 || i == 6) update(32'h300 + 32'(4 * i), t, t);
            else                            update(32'h300 + 32'(4 * i), t, ~t);
            if (oMispredict) pulses++;
            idle(); cycle();
            if (oMispredict) pulses++;
        end
        chk("mispredict_pulses", pulses, 5);
        chk("miss_count_delta", oMissCount - 16'(miss_before), 5);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            iPredValid    = 1'($urandom);
            iPredPC       = $urandom;
            iUpdValid     = 1'($urandom);
            iUpdPC        = (i % 3 == 0) ? iPredPC : $urandom;
            iUpdTaken     = 1'($urandom);
            iUpdPredTaken = ($urandom_range(0, 3) == 0) ? ~iUpdTaken : iUpdTaken;
            cycle();
        end

        // Reset mid-operation after training 0x10C to strongly taken
        for (int i = 0; i < 4; i++) update(32'h10C, 1, 1);
        predict(32'h10C);
        chk("pre_reset_0x10C", oPredTaken, 1);
        iPredValid = 1; iPredPC = 32'h10C;
        do_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            iPredValid    = 1'($urandom);
            iPredPC       = $urandom;
            iUpdValid     = 1'($urandom);
            iUpdPC        = $urandom;
            iUpdTaken     = 1'($urandom);
            iUpdPredTaken = ~iUpdTaken;
            cycle();
            if (i < ENTRIES - 1) chk("init_no_pred_valid", oPredValid, 0);
        end
        chk("ready_after_reinit", oReady, 1);
        chk("miss_after_reinit", oMissCount, 0);
        predict(32'h10C);
        chk("post_reset_0x10C", oPredTaken, 0);

        // Force 70000 mispredicts: counter saturates
        for (int i = 0; i < 70000; i++) begin
            idle();
            iUpdValid = 1; iUpdPC = $urandom;
            iUpdTaken = 1'($urandom); iUpdPredTaken = ~iUpdTaken;
            cycle();
        end
        chk("miss_saturated", oMissCount, 16'hFFFF);
        idle(); cycle();
        chk("miss_hold", oMissCount, 16'hFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Bimodal branch direction predictor for the rv32 pipeline. Fetch queries it with a branch PC and gets a registered taken/not-taken guess one cycle later. Execute, after the branch comparator resolves the real condition, writes the outcome back to train a table of 2-bit saturating counters and to flag mispredictions. It is the consumer end of the branch-condition path: comparators produce outcomes, and this block learns from them.

## Interface
Parameters:
- Entries, 64, number of 2-bit counters; power of two, 4 to 1024.
- IdxBits, $clog2(Entries), index width; index = PC[IdxBits+1:2].

Ports:
- iClk  in  1  clock, all state updates on rising edge.
- nRst  in  1  reset, asynchronous, active-low.
- iPredValid  in  1  prediction request this cycle.
- iPredPC  in  RegWidth  PC of branch being fetched.
- oPredValid  out  1  registered; prediction result valid.
- oPredTaken  out  1  registered; counter MSB of indexed entry.
- iUpdValid  in  1  resolved-branch update this cycle.
- iUpdPC  in  RegWidth  PC of resolved branch.
- iUpdTaken  in  1  actual outcome from branch comparison.
- iUpdPredTaken  in  1  prediction the pipeline used for this branch.
- oMispredict  out  1  registered one-cycle pulse; iUpdTaken != iUpdPredTaken.
- oMissCount  out  16  saturating count of mispredictions since reset.
- oReady  out  1  high once table initialisation completes.

## Operation
- FSM states: INIT, RUN.
- On reset the FSM enters INIT with the sweep pointer at 0. In INIT, one entry per cycle is written to 2'b01 (weakly not-taken). The pointer increments; after writing entry Entries-1 the FSM goes to RUN. The FSM never leaves RUN except by reset.
- INIT:
  - oReady = 0.
  - iPredValid and iUpdValid are ignored.
  - oPredValid = 0, oMispredict = 0, oMissCount is not incremented.
- RUN prediction:
  - When iPredValid, the next cycle sets oPredValid = 1 and oPredTaken = table[iPredPC idx][1].
  - Otherwise oPredValid = 0. oPredTaken holds its last value.
- RUN update (iUpdValid):
  - Counter moves toward iUpdTaken: taken increments and saturates at 3; not-taken decrements and saturates at 0.
  - oMispredict pulses the next cycle if iUpdTaken != iUpdPredTaken.
  - On each misprediction, oMissCount increments, saturating at 16'hFFFF.
- Aliasing: PCs with equal PC[IdxBits+1:2] share one counter. PC[1:0] and the upper bits are ignored.
- Same-cycle prediction and update to the same index: the prediction returns the pre-update counter (read-before-write). The update still commits.
- Reset mid-operation: every output returns to its reset value immediately (asynchronously), and a full INIT sweep restarts.

## Timing
- Reset values: oPredValid 0, oPredTaken 0, oMispredict 0, oMissCount 0, oReady 0, FSM INIT, sweep pointer 0.
- oReady rises on the Entries-th rising edge after nRst deasserts, i.e. 64 cycles at the default.
- Prediction latency: 1 cycle, full throughput of one request per cycle.
- Update latency: the counter write is visible to a prediction issued on the next cycle. oMispredict and the oMissCount change appear 1 cycle after iUpdValid.
- No backpressure. Requests in RUN are always accepted.

## Test plan
- Reset, then 64 idle cycles: oReady is 0 through cycle 63 and 1 at cycle 64. Then predict PC 0x0000_0100 and PC 0x0000_01FC: oPredTaken = 0 for both.
- Train taken at PC 0x100: first update leads to prediction taken (01→10), oPredTaken = 1. Then predict PC 0x200 (aliases index 0 at 64 entries): oPredTaken = 1.
- Saturation:
  - Four taken updates at PC 0x104 leave the counter at 3. One not-taken update gives 2, and the prediction stays 1.
  - Then three not-taken updates leave the counter at 0, and the prediction is 0.
- Same-cycle predict and update at PC 0x108, counter 01, update taken: the same-cycle prediction is 0 and the following-cycle prediction is 1.
- Misprediction:
  - 5 updates with iUpdTaken != iUpdPredTaken, interleaved with 3 matching ones: exactly 5 single-cycle oMispredict pulses and oMissCount = 5.
  - Force 70000 mispredicts: oMissCount = 16'hFFFF.
- Reset mid-operation:
  - Train PC 0x10C to 3, then pulse nRst low for one cycle mid-stream. All outputs are 0 immediately and oReady stays 0 for 64 cycles.
  - Predict and update requests during INIT produce no oPredValid or oMispredict.
  - After INIT, PC 0x10C predicts 0.
